// File: rtl/iterative_divider_pkg.sv
// Shared definitions for the iterative restoring divider.
// Holds the FSM encoding and the divide-by-zero quotient constant.
package iterative_divider_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
  localparam int                   MAX_WIDTH    = 128;
  localparam logic [MAX_WIDTH-1:0] DBZ_QUOTIENT = '1;

endpackage

// File: rtl/iterative_divider_if.sv
// Request/result bundle between the core and the iterative divider.
interface iterative_divider_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  ready, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output ready, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/iterative_divider_subtractor.sv
// Generic ripple subtractor: Result = DataA - DataB - BorrowIn.
// ExtendedBits gives headroom so the borrow appears in bit NrOfBits.
module iterative_divider_subtractor #(
  parameter int NrOfBits     = 33,
  parameter int ExtendedBits = 34
) (
  input  logic [NrOfBits-1:0] DataA,
  input  logic [NrOfBits-1:0] DataB,
  input  logic                BorrowIn,
  output logic [NrOfBits-1:0] Result,
  output logic                BorrowOut
);

  logic [ExtendedBits-1:0] w_a_ext;
  logic [ExtendedBits-1:0] w_b_ext;
  logic [ExtendedBits-1:0] w_cin_ext;
  logic [ExtendedBits-1:0] w_diff;

  assign w_a_ext   = {{(ExtendedBits-NrOfBits){1'b0}}, DataA};
  assign w_b_ext   = {{(ExtendedBits-NrOfBits){1'b0}}, DataB};
  assign w_cin_ext = {{(ExtendedBits-1){1'b0}}, BorrowIn};
  assign w_diff    = w_a_ext - w_b_ext - w_cin_ext;

  assign Result    = w_diff[NrOfBits-1:0];
  assign BorrowOut = w_diff[NrOfBits];

endmodule

// File: rtl/iterative_divider.sv
// Multi-cycle restoring divider for DIV/DIVU/REM/REMU: one trial subtraction
// per cycle over WIDTH cycles, with sign fix-up applied as results are written.
module iterative_divider
  import iterative_divider_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int CNT_BITS = 5
) (
  input  logic               clock,
  input  logic               reset,
  iterative_divider_if.slave bus
);

  state_t              r_state;
  logic [CNT_BITS-1:0] r_cnt;
  logic [WIDTH-1:0]    r_dvd;       // dividend magnitude, quotient bits shift in at LSB
  logic [WIDTH-1:0]    r_dvd_orig;
  logic [WIDTH-1:0]    r_div_mag;
  logic [WIDTH-1:0]    r_rem;
  logic                r_neg_rem;
  logic                r_neg_quo;
  logic                r_dbz_flag;

  logic                r_ready;
  logic                r_done;
  logic [WIDTH-1:0]    r_quotient;
  logic [WIDTH-1:0]    r_remainder;
  logic                r_div_by_zero;

  logic             w_dvd_neg;
  logic             w_div_neg;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_div_mag;
  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_trial;
  logic             w_borrow;
  logic             w_borrow_unused;
  logic [WIDTH-1:0] w_rem_next;
  logic [WIDTH-1:0] w_quo_next;
  logic [WIDTH-1:0] w_quo_fixed;
  logic [WIDTH-1:0] w_rem_fixed;
  logic             w_last_iter;

  assign w_dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
  assign w_div_neg = bus.is_signed & bus.divisor[WIDTH-1];
  assign w_dvd_mag = w_dvd_neg ? (~bus.dividend + WIDTH'(1)) : bus.dividend;
  assign w_div_mag = w_div_neg ? (~bus.divisor + WIDTH'(1)) : bus.divisor;

  assign w_shifted = {r_rem, r_dvd[WIDTH-1]};

  iterative_divider_subtractor #(
    .NrOfBits     (WIDTH + 1),
    .ExtendedBits (WIDTH + 2)
  ) u_sub (
    .DataA     (w_shifted),
    .DataB     ({1'b0, r_div_mag}),
    .BorrowIn  (1'b0),
    .Result    (w_trial),
    .BorrowOut (w_borrow_unused)
  );

  // The trial result's top bit is the borrow; the subtractor's own borrow port is not needed.
  assign w_borrow    = w_trial[WIDTH];
  assign w_rem_next  = w_borrow ? w_shifted[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign w_quo_next  = {r_dvd[WIDTH-2:0], ~w_borrow};
  assign w_quo_fixed = r_neg_quo ? (~w_quo_next + WIDTH'(1)) : w_quo_next;
  assign w_rem_fixed = r_neg_rem ? (~w_rem_next + WIDTH'(1)) : w_rem_next;
  assign w_last_iter = (r_cnt == CNT_BITS'(WIDTH - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_dvd         <= '0;
      r_dvd_orig    <= '0;
      r_div_mag     <= '0;
      r_rem         <= '0;
      r_neg_rem     <= 1'b0;
      r_neg_quo     <= 1'b0;
      r_dbz_flag    <= 1'b0;
      r_ready       <= 1'b1;
      r_done        <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_dvd      <= w_dvd_mag;
            r_dvd_orig <= bus.dividend;
            r_div_mag  <= w_div_mag;
            r_rem      <= '0;
            r_neg_rem  <= w_dvd_neg;
            r_neg_quo  <= w_dvd_neg ^ w_div_neg;
            r_dbz_flag <= (bus.divisor == '0);
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_rem <= w_rem_next;
          r_dvd <= w_quo_next;
          r_cnt <= r_cnt + CNT_BITS'(1);
          if (w_last_iter) begin
            r_done        <= 1'b1;
            r_div_by_zero <= r_dbz_flag;
            if (r_dbz_flag) begin
              r_quotient  <= DBZ_QUOTIENT[WIDTH-1:0];
              r_remainder <= r_dvd_orig;
            end else begin
              r_quotient  <= w_quo_fixed;
              r_remainder <= w_rem_fixed;
            end
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
        default: begin
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.ready       = r_ready;
  assign bus.done        = r_done;
  assign bus.quotient    = r_quotient;
  assign bus.remainder   = r_remainder;
  assign bus.div_by_zero = r_div_by_zero;

endmodule
